// File: rtl/csi_rx_raw10_unpack.sv
`default_nettype none
// ============================================================================
// Module   : csi_rx_raw10_unpack
// Brief    : Unpacks CSI-2 RAW10 payload words into 4-pixel beats, tracking
//            line byte count, frame start, line end and malformed lines.
// Revision : 1.0 - initial release
// ============================================================================
module csi_rx_raw10_unpack (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        FSYNC,
    input  logic        VALID,
    input  logic [31:0] DIN,
    input  logic [15:0] WC,
    output logic        PIX_VALID,
    output logic [39:0] PIX,
    output logic        SOF,
    output logic        EOL,
    output logic [15:0] LINE_CNT,
    output logic        ERR
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LINE = 2'd1,
        ST_IN_LINE   = 2'd2
    } state_t;

    state_t      r_state;
    logic [63:0] r_acc;
    logic [3:0]  r_occ;
    logic [15:0] r_rem;
    logic        r_sof_pend;

    logic        w_first;
    logic [15:0] w_base_rem;
    logic [3:0]  w_base_occ;
    logic [63:0] w_base_acc;
    logic [2:0]  w_n;
    logic [31:0] w_din_m;
    logic [63:0] w_acc_app;
    logic [3:0]  w_occ_app;
    logic [15:0] w_rem_next;
    logic        w_grp;
    logic [63:0] w_acc_next;
    logic [3:0]  w_occ_next;
    logic [39:0] w_pix;
    logic        w_done;
    logic        w_accept;
    logic        w_wc_zero;

    always_comb begin
        w_first    = (r_state == ST_WAIT_LINE);
        // The first word of a line starts from WC and an empty accumulator
        w_base_rem = w_first ? WC    : r_rem;
        w_base_occ = w_first ? 4'd0  : r_occ;
        w_base_acc = w_first ? 64'd0 : r_acc;
        w_n        = (w_base_rem >= 16'd4) ? 3'd4 : w_base_rem[2:0];

        w_din_m = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < w_n) begin
                w_din_m[8*i +: 8] = DIN[8*i +: 8];
            end
        end

        w_acc_app  = w_base_acc | ({32'd0, w_din_m} << {w_base_occ, 3'b000});
        w_occ_app  = w_base_occ + {1'b0, w_n};
        w_rem_next = w_base_rem - {13'd0, w_n};
        w_grp      = (w_occ_app >= 4'd5);
        w_acc_next = w_grp ? (w_acc_app >> 40) : w_acc_app;
        w_occ_next = w_grp ? (w_occ_app - 4'd5) : w_occ_app;

        // Byte 4 of the group carries the two LSBs of each of the four pixels
        w_pix = 40'd0;
        for (int k = 0; k < 4; k++) begin
            w_pix[10*k +: 10] = {w_acc_app[8*k +: 8], w_acc_app[32 + 2*k +: 2]};
        end

        w_done    = (w_rem_next == 16'd0);
        w_accept  = VALID && !FSYNC && (r_state != ST_IDLE);
        w_wc_zero = w_first && (WC == 16'd0);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state    <= ST_IDLE;
            r_acc      <= 64'd0;
            r_occ      <= 4'd0;
            r_rem      <= 16'd0;
            r_sof_pend <= 1'b0;
            PIX_VALID  <= 1'b0;
            PIX        <= 40'd0;
            SOF        <= 1'b0;
            EOL        <= 1'b0;
            ERR        <= 1'b0;
            LINE_CNT   <= 16'd0;
        end else begin
            PIX_VALID <= 1'b0;
            SOF       <= 1'b0;
            EOL       <= 1'b0;
            ERR       <= 1'b0;
            if (FSYNC) begin
                r_state    <= ST_WAIT_LINE;
                r_sof_pend <= 1'b1;
                LINE_CNT   <= 16'd0;
                r_acc      <= 64'd0;
                r_occ      <= 4'd0;
                r_rem      <= 16'd0;
                ERR        <= (r_state == ST_IN_LINE);
            end else if (w_accept) begin
                if (w_wc_zero) begin
                    ERR <= 1'b1;
                end else begin
                    if (w_grp) begin
                        PIX_VALID  <= 1'b1;
                        PIX        <= w_pix;
                        SOF        <= r_sof_pend;
                        r_sof_pend <= 1'b0;
                        EOL        <= w_done && (w_occ_next == 4'd0);
                    end
                    if (w_done) begin
                        // Any bytes left over are an incomplete pixel group
                        LINE_CNT <= LINE_CNT + 16'd1;
                        r_state  <= ST_WAIT_LINE;
                        r_acc    <= 64'd0;
                        r_occ    <= 4'd0;
                        r_rem    <= 16'd0;
                        ERR      <= (w_occ_next != 4'd0);
                    end else begin
                        r_state <= ST_IN_LINE;
                        r_acc   <= w_acc_next;
                        r_occ   <= w_occ_next;
                        r_rem   <= w_rem_next;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csi_rx_raw10_unpack.sv
`default_nettype none
// ============================================================================
// Module   : tb_csi_rx_raw10_unpack
// Brief    : Self-checking bench for csi_rx_raw10_unpack against a byte-queue
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csi_rx_raw10_unpack;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        FSYNC;
    logic        VALID;
    logic [31:0] DIN;
    logic [15:0] WC;
    logic        PIX_VALID;
    logic [39:0] PIX;
    logic        SOF;
    logic        EOL;
    logic [15:0] LINE_CNT;
    logic        ERR;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    csi_rx_raw10_unpack u_dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .FSYNC     (FSYNC),
        .VALID     (VALID),
        .DIN       (DIN),
        .WC        (WC),
        .PIX_VALID (PIX_VALID),
        .PIX       (PIX),
        .SOF       (SOF),
        .EOL       (EOL),
        .LINE_CNT  (LINE_CNT),
        .ERR       (ERR)
    );

    // Reference model: 0 idle, 1 waiting for line, 2 inside line
    int           m_state;
    int           m_rem;
    byte unsigned m_q[$];
    bit           m_sof_pend;
    int           m_lines;

    task automatic model_reset();
        m_state    = 0;
        m_rem      = 0;
        m_q.delete();
        m_sof_pend = 0;
        m_lines    = 0;
    endtask

    // Expected bundle: {pv, pix[39:0], sof, eol, err, line_cnt[15:0]}
    task automatic model_step(input bit fs, input bit v, input logic [31:0] d,
                              input logic [15:0] w, output logic [59:0] exp);
        logic         pv, sof, eol, err;
        logic [39:0]  pix;
        bit           take;
        byte unsigned b[5];
        pv = 0; sof = 0; eol = 0; err = 0; pix = 40'd0; take = 1;
        if (fs) begin
            if (m_state == 2) err = 1;
            m_state    = 1;
            m_sof_pend = 1;
            m_lines    = 0;
            m_q.delete();
        end else if (v && m_state != 0) begin
            if (m_state == 1) begin
                if (w == 16'd0) begin
                    err  = 1;
                    take = 0;
                end else begin
                    m_rem   = int'(w);
                    m_q.delete();
                    m_state = 2;
                end
            end
            if (take) begin
                for (int i = 0; i < 4; i++) begin
                    if (m_rem > 0) begin
                        m_q.push_back(d[8*i +: 8]);
                        m_rem--;
                    end
                end
                if (m_q.size() >= 5) begin
                    for (int i = 0; i < 5; i++) b[i] = m_q.pop_front();
                    for (int k = 0; k < 4; k++)
                        pix[10*k +: 10] = 10'(int'(b[k]) * 4 + ((int'(b[4]) >> (2*k)) & 3));
                    pv         = 1;
                    sof        = m_sof_pend;
                    m_sof_pend = 0;
                end
                if (m_rem == 0) begin
                    m_lines++;
                    m_state = 1;
                    err     = (m_q.size() != 0);
                    eol     = pv && (m_q.size() == 0);
                    m_q.delete();
                end
            end
        end
        exp = {pv, pix, sof, eol, err, 16'(m_lines)};
    endtask

    task automatic cycle(input bit fs, input bit v, input logic [31:0] d,
                         input logic [15:0] w, output logic [59:0] exp,
                         output logic [59:0] obs);
        FSYNC = fs; VALID = v; DIN = d; WC = w;
        model_step(fs, v, d, w, exp);
        @(posedge CLK);
        #1;
        obs   = {PIX_VALID, (PIX_VALID ? PIX : 40'd0), SOF, EOL, ERR, LINE_CNT};
        FSYNC = 1'b0;
        VALID = 1'b0;
    endtask

    task automatic test_reset();
        logic [59:0] e, o;
        RST_N = 1'b0; FSYNC = 1'b0; VALID = 1'b0; DIN = 32'd0; WC = 16'd0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({PIX_VALID, PIX, SOF, EOL, ERR, LINE_CNT} !== 60'd0) begin
            $display("FAIL reset_values: got %h required 0",
                     {PIX_VALID, PIX, SOF, EOL, ERR, LINE_CNT});
            errors++;
        end
        RST_N = 1'b1;
        cycle(0, 1, 32'h03020100, 16'd10, e, o);
        checks++;
        if (o !== 60'd0) begin
            $display("FAIL valid_without_fsync: got %h required 0", o);
            errors++;
        end
    endtask

    task automatic test_basic_wc10();
        logic [59:0] e, o;
        logic [31:0] words[3];
        logic [39:0] beat1, beat2;
        words = '{32'h03020100, 32'h07060504, 32'h0B0A0908};
        beat1 = {10'h00C, 10'h008, 10'h005, 10'h000};
        beat2 = {10'h020, 10'h01C, 10'h01A, 10'h015};
        cycle(1, 0, 32'd0, 16'd0, e, o);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, words[i], 16'd10, e, o);
            checks++;
            if (o !== e) begin
                $display("FAIL basic_word%0d: got %h required %h", i, o, e);
                errors++;
            end
            if (i == 1) begin
                checks++;
                if ({o[59], o[58:19], o[18], o[16]} !== {1'b1, beat1, 1'b1, 1'b0}) begin
                    $display("FAIL basic_beat1: got pix %h sof %b required pix %h sof 1",
                             o[58:19], o[18], beat1);
                    errors++;
                end
            end
            if (i == 2) begin
                checks++;
                if ({o[59], o[58:19], o[17], o[16], o[15:0]} !==
                    {1'b1, beat2, 1'b1, 1'b0, 16'd1}) begin
                    $display("FAIL basic_beat2: got pix %h eol %b err %b lines %0d required pix %h eol 1 err 0 lines 1",
                             o[58:19], o[17], o[16], o[15:0], beat2);
                    errors++;
                end
            end
        end
    endtask

    task automatic test_two_lines();
        logic [59:0] e, o;
        int beats, sofs, eols;
        beats = 0; sofs = 0; eols = 0;
        cycle(1, 0, 32'd0, 16'd0, e, o);
        for (int ln = 0; ln < 2; ln++) begin
            for (int i = 0; i < 5; i++) begin
                cycle(0, 1, $urandom, 16'd20, e, o);
                checks++;
                if (o !== e) begin
                    $display("FAIL two_lines_l%0d_w%0d: got %h required %h", ln, i, o, e);
                    errors++;
                end
                beats += int'(o[59]); sofs += int'(o[18]); eols += int'(o[17]);
                cycle(0, 0, $urandom, 16'd20, e, o);
                checks++;
                if (o !== e) begin
                    $display("FAIL two_lines_gap: got %h required %h", o, e);
                    errors++;
                end
            end
        end
        checks++;
        if ({beats, sofs, eols, 16'(LINE_CNT)} !== {32'd8, 32'd1, 32'd2, 16'd2}) begin
            $display("FAIL two_lines_totals: got beats %0d sof %0d eol %0d lines %0d required 8 1 2 2",
                     beats, sofs, eols, LINE_CNT);
            errors++;
        end
    endtask

    task automatic test_residue();
        logic [59:0] e, o;
        cycle(1, 0, 32'd0, 16'd0, e, o);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, $urandom, 16'd12, e, o);
            checks++;
            if (o !== e) begin
                $display("FAIL residue_w%0d: got %h required %h", i, o, e);
                errors++;
            end
        end
        checks++;
        if ({o[59], o[17], o[16], o[15:0]} !== {1'b1, 1'b0, 1'b1, 16'd1}) begin
            $display("FAIL residue_end: got pv %b eol %b err %b lines %0d required 1 0 1 1",
                     o[59], o[17], o[16], o[15:0]);
            errors++;
        end
    endtask

    task automatic test_abort();
        logic [59:0] e, o;
        cycle(1, 0, 32'd0, 16'd0, e, o);
        cycle(0, 1, $urandom, 16'd20, e, o);
        cycle(0, 1, $urandom, 16'd20, e, o);
        cycle(1, 1, $urandom, 16'd20, e, o);
        checks++;
        if ({o[59], o[16], o[15:0]} !== {1'b0, 1'b1, 16'd0}) begin
            $display("FAIL abort_err: got pv %b err %b lines %0d required 0 1 0",
                     o[59], o[16], o[15:0]);
            errors++;
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, $urandom, 16'd10, e, o);
            checks++;
            if (o !== e) begin
                $display("FAIL abort_next_w%0d: got %h required %h", i, o, e);
                errors++;
            end
            if (i == 1) begin
                checks++;
                if ({o[59], o[18]} !== 2'b11) begin
                    $display("FAIL abort_sof: got pv %b sof %b required 1 1", o[59], o[18]);
                    errors++;
                end
            end
        end
    endtask

    task automatic test_wc_zero();
        logic [59:0] e, o;
        cycle(1, 0, 32'd0, 16'd0, e, o);
        cycle(0, 1, $urandom, 16'd0, e, o);
        checks++;
        if ({o[59], o[16], o[15:0]} !== {1'b0, 1'b1, 16'd0}) begin
            $display("FAIL wc_zero: got pv %b err %b lines %0d required 0 1 0",
                     o[59], o[16], o[15:0]);
            errors++;
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, $urandom, 16'd10, e, o);
            checks++;
            if (o !== e) begin
                $display("FAIL wc_zero_next_w%0d: got %h required %h", i, o, e);
                errors++;
            end
        end
    endtask

    task automatic test_reset_midline();
        logic [59:0] e, o;
        cycle(1, 0, 32'd0, 16'd0, e, o);
        cycle(0, 1, $urandom, 16'd20, e, o);
        cycle(0, 1, $urandom, 16'd20, e, o);
        RST_N = 1'b0;
        model_reset();
        cycle(0, 1, $urandom, 16'd20, e, o);
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, $urandom, 16'd20, e, o);
            checks++;
            if (o !== 60'd0) begin
                $display("FAIL reset_midline_w%0d: got %h required 0", i, o);
                errors++;
            end
        end
    endtask

    task automatic test_random();
        logic [59:0] e, o;
        bit          fs, v;
        for (int n = 0; n < 600; n++) begin
            fs = ($urandom_range(0, 39) == 0);
            v  = ($urandom_range(0, 9) < 6);
            cycle(fs, v, $urandom, 16'($urandom_range(0, 40)), e, o);
            checks++;
            if (o !== e) begin
                $display("FAIL random_cycle%0d: got %h required %h", n, o, e);
                errors++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_wc10();
        test_two_lines();
        test_residue();
        test_abort();
        test_wc_zero();
        test_reset_midline();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
